fp16_mult_scheduler: RTL and testbench
======================================

Name: fp16_mult_scheduler

Overview:
- Shares one free-running FP16 (1/5/10, bias 15) multiplier pipeline among NUM_REQ requesters.
- Arbitrates operand pairs round-robin and drives them into the multiplier.
- Tracks in-flight operations with a tag pipeline matched to the multiplier latency.
- Returns each product to its owner as a one-cycle response pulse. Sits between the operand sources (switch/constant loaders) and the multiplier plus 7-segment output path.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MULT_LAT, 4, cycles from operands presented on mult_a/mult_b to the matching mult_result; legal range 1..8.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  operand A; requester i on bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B; same packing.
- mult_a  out  16  operand A to the multiplier.
- mult_b  out  16  operand B to the multiplier.
- mult_start  out  1  marks a live operand pair on mult_a/mult_b.
- mult_result  in  16  multiplier product.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_data  out  16  product for the strobed requester.
- busy  out  NUM_REQ  requester i has an operation in flight.

Behaviour:
- Reset (asynchronous, reset_n low): the following clear to 0 immediately:
  - busy, rsp_valid, rsp_data, mult_a, mult_b, mult_start
  - tag pipeline
  - round-robin pointer (requester 0 has highest priority after reset)
- Reset asserted mid-operation: all in-flight products are discarded and no rsp_valid is issued for them.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i]. Each requester has at most one operation in flight.
- Arbitration:
  - Combinational, at most one grant per cycle.
  - Search starts at (last_grant+1) mod NUM_REQ and picks the first eligible requester.
  - req_ready = grant one-hot; handshake completes when req_valid[i] & req_ready[i].
  - Requesters must not make req_valid depend on req_ready.
  - Pointer updates to the granted index only on a handshake; otherwise it holds.
- Issue, handshake cycle T:
  - At edge T+1: mult_a/mult_b load the granted operands, mult_start=1, busy[i] set.
  - The tag pipeline stage 0 loads {valid=1, id=i}.
  - With no grant, mult_start=0 and mult_a/mult_b hold their previous values.
- Tag pipeline:
  - MULT_LAT stages, {valid, id} with id width clog2(NUM_REQ); shifts every cycle unconditionally.
  - The multiplier is free-running, so there is no stall.
- Return:
  - When the final tag stage is valid, mult_result is captured into rsp_data at the next edge.
  - In that same cycle, rsp_valid[id]=1 and busy[id] clears.
  - Total latency is handshake at T to rsp_valid at T+MULT_LAT+2.
- Responses have no backpressure. rsp_valid is high exactly one cycle; rsp_data holds until the next response.
- Re-issue: busy[i] is low in the cycle rsp_valid[i] is high, so requester i can handshake in that same cycle.
- Throughput: one operation per cycle across requesters; one operation per MULT_LAT+2 cycles per requester.
- Simultaneous events:
  - A grant and a return in the same cycle are independent and both occur.
  - A return to i and a new grant to j≠i in the same cycle is legal.
- No arithmetic is performed in this block. The sign, exponent and mantissa of mult_result are passed through unaltered.

Optional Feature:
- Macro: FP16_SCHED_STATS_EN.
- Defined: adds outputs stat_grants (16 bit) and stat_conflicts (16 bit).
  - stat_grants counts handshakes.
  - stat_conflicts counts cycles with ≥2 eligible requesters.
  - Both counters saturate at 0xFFFF and clear on reset.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Req0 issues a=0xC41A (-4.1), b=0x4580 (5.5), MULT_LAT=4, bench multiplier model:
  - Expect req_ready[0] at T.
  - Expect mult_start at T+1.
  - Expect rsp_valid=4'b0001, rsp_data=0xCDA4 at T+6.
- All four requesters valid continuously from reset:
  - Grants in order 0,1,2,3.
  - Requester 0 is regranted in its rsp cycle.
  - Responses return in grant order, each with the correct operands' product (e.g. 0x441A*0x4580=0x4DA4).
- Req2 busy, req2 and req3 both valid: grant goes to req3; req2 stays unready until its rsp_valid cycle.
- Assert reset_n low for 1 cycle with 3 ops in flight:
  - All outputs go to 0 asynchronously.
  - No rsp_valid is issued for the flushed tags.
  - After release, req0 wins first.
- No requests for 20 cycles: mult_start=0, rsp_valid=0 throughout, and mult_a/mult_b hold their last values.
- With FP16_SCHED_STATS_EN, 10 handshakes including 3 contended cycles: stat_grants=10, stat_conflicts=3. With the counters preloaded near the limit, both saturate at 0xFFFF.

Source files
------------

// File: rtl/fp16_mult_scheduler.sv
// ----------------------------------------------------------------------------
// fp16_mult_scheduler
//
// Shares one free-running FP16 (1/5/10, bias 15) multiplier pipeline among
// NUM_REQ requesters. Operand pairs are arbitrated round-robin and issued to
// the multiplier. A tag pipeline follows each operation through the
// multiplier and returns its product to the owner as a one-cycle strobe.
// No arithmetic happens here; mult_result is passed through bit for bit.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   MULT_LAT  cycles from operands on mult_a/mult_b to matching mult_result (1..8)
//
// Ports
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   req_valid       per-requester operand-pair valid
//   req_ready       per-requester accept, one-hot or zero
//   req_a, req_b    packed operands, requester i on bits [16i+15:16i]
//   mult_a, mult_b  operands to the multiplier
//   mult_start      live operand pair on mult_a/mult_b
//   mult_result     multiplier product
//   rsp_valid       one-hot, one-cycle response strobe
//   rsp_data        product for the strobed requester, held until next response
//   busy            requester i has an operation in flight
//
// Optional build macro FP16_SCHED_STATS_EN adds
//   stat_grants     saturating count of handshakes
//   stat_conflicts  saturating count of cycles with two or more eligible requesters
// ----------------------------------------------------------------------------
module fp16_mult_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [15:0]           mult_a,
    output logic [15:0]           mult_b,
    output logic                  mult_start,
    input  logic [15:0]           mult_result,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_data,
    output logic [NUM_REQ-1:0]    busy
`ifdef FP16_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_grants,
    output logic [15:0]           stat_conflicts
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;

    // Stage 0 tracks the pair sitting on mult_a/mult_b; stages 1..MULT_LAT
    // follow it through the multiplier, so the last stage lines up with the
    // cycle its product appears on mult_result.
    logic [MULT_LAT:0]  tag_valid;
    logic [ID_W-1:0]    tag_id [MULT_LAT+1];

    logic               ret_any;
    logic [ID_W-1:0]    ret_id;
    logic [NUM_REQ-1:0] ret_onehot;
    logic [NUM_REQ-1:0] busy_next;

    assign eligible = req_valid & ~busy;

    // rr_ptr holds the first index to search, i.e. last grant + 1; clearing
    // it on reset gives requester 0 top priority.
    always_comb begin : arbiter
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && eligible[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign sel_a     = req_a[{grant_idx, 4'b0000} +: 16];
    assign sel_b     = req_b[{grant_idx, 4'b0000} +: 16];
    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign ret_any = tag_valid[MULT_LAT];
    assign ret_id  = tag_id[MULT_LAT];

    always_comb begin : return_decode
        ret_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ret_onehot[i] = ret_any && (32'(ret_id) == i);
        end
    end

    // A returning requester is always busy and a granted one never is, so
    // the clear and the set can never hit the same bit.
    assign busy_next = (busy & ~ret_onehot) | grant;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            mult_start <= 1'b0;
            busy       <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            tag_valid  <= '0;
            for (int unsigned s = 0; s <= MULT_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            mult_start <= grant_any;
            if (grant_any) begin
                mult_a <= sel_a;
                mult_b <= sel_b;
                rr_ptr <= ptr_next;
            end
            tag_valid <= {tag_valid[MULT_LAT-1:0], grant_any};
            tag_id[0] <= grant_idx;
            for (int unsigned s = 1; s <= MULT_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            busy      <= busy_next;
            rsp_valid <= ret_onehot;
            if (ret_any) begin
                rsp_data <= mult_result;
            end
        end
    end

`ifdef FP16_SCHED_STATS_EN
    logic contended;

    assign contended = ($countones(eligible) > 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant_any && (stat_grants != 16'hFFFF)) begin
                stat_grants <= stat_grants + 16'd1;
            end
            if (contended && (stat_conflicts != 16'hFFFF)) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp16_mult_scheduler.sv
module tb_fp16_mult_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int MULT_LAT = 4;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [15:0]           mult_a;
    logic [15:0]           mult_b;
    logic                  mult_start;
    logic [15:0]           mult_result;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [15:0]           rsp_data;
    logic [NUM_REQ-1:0]    busy;
`ifdef FP16_SCHED_STATS_EN
    logic [15:0]           stat_grants;
    logic [15:0]           stat_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fp16_mult_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_start  (mult_start),
        .mult_result (mult_result),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
`ifdef FP16_SCHED_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // Multiplier stand-in: table of hand-computed FP16 products, pushed
    // through a free-running MULT_LAT-deep pipeline.
    function automatic logic [15:0] fp_lut(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'hC41A_4580: return 16'hCDA4;  // -4.1 * 5.5
            32'h441A_4580: return 16'h4DA4;  //  4.1 * 5.5
            32'h4000_4200: return 16'h4600;  //  2 * 3 = 6
            32'h3C00_4500: return 16'h4500;  //  1 * 5 = 5
            32'h4400_4400: return 16'h4C00;  //  4 * 4 = 16
            32'hC000_3800: return 16'hBC00;  // -2 * 0.5 = -1
            default:       return 16'h7E00;
        endcase
    endfunction

    logic [15:0] mpipe [MULT_LAT];

    always @(posedge clock) begin
        mpipe[0] <= fp_lut(mult_a, mult_b);
        for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
    end

    assign mult_result = mpipe[MULT_LAT-1];

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic test_reset();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        checks++; if (mult_a !== 16'h0000) begin errors++; $display("FAIL reset_mult_a: got %h want 0000", mult_a); end
        checks++; if (mult_b !== 16'h0000) begin errors++; $display("FAIL reset_mult_b: got %h want 0000", mult_b); end
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL reset_mult_start: got %b want 0", mult_start); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
`ifdef FP16_SCHED_STATS_EN
        checks++; if (stat_grants !== 16'h0000) begin errors++; $display("FAIL reset_stat_grants: got %h want 0000", stat_grants); end
`endif
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        // cycle T
        set_ops(0, 16'hC41A, 16'h4580);
        req_valid = 4'b0001;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready_T: got %b want 0001", req_ready); end
        cyc();  // T+1
        req_valid = '0;
        checks++; if (mult_start !== 1'b1) begin errors++; $display("FAIL single_mult_start: got %b want 1", mult_start); end
        checks++; if (mult_a !== 16'hC41A) begin errors++; $display("FAIL single_mult_a: got %h want c41a", mult_a); end
        checks++; if (mult_b !== 16'h4580) begin errors++; $display("FAIL single_mult_b: got %h want 4580", mult_b); end
        checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL single_busy: got %b want 0001", busy); end
        for (int t = 2; t <= 5; t++) begin
            cyc();
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp T+%0d: got %b want 0000", t, rsp_valid); end
        end
        cyc();  // T+6
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        checks++; if (rsp_data !== 16'hCDA4) begin errors++; $display("FAIL single_rsp_data: got %h want cda4", rsp_data); end
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL single_busy_clear: got %b want 0000", busy); end
        cyc();  // T+7
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_one_cycle: got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 16'hCDA4) begin errors++; $display("FAIL single_rsp_hold: got %h want cda4", rsp_data); end
    endtask

    task automatic test_all4();
        logic [3:0]  exp_rdy [10];
        logic [3:0]  exp_rsp [10];
        logic [15:0] exp_dat [10];
        exp_rdy = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
        exp_rsp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
        exp_dat = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                    16'h4DA4, 16'h4600, 16'h4500, 16'h4C00};
        reset_n = 1'b0;
        set_ops(0, 16'h441A, 16'h4580);
        set_ops(1, 16'h4000, 16'h4200);
        set_ops(2, 16'h3C00, 16'h4500);
        set_ops(3, 16'h4400, 16'h4400);
        req_valid = 4'b1111;
        cyc();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL all4_ready c%0d: got %b want %b", c, req_ready, exp_rdy[c]); end
            checks++; if (rsp_valid !== exp_rsp[c]) begin errors++; $display("FAIL all4_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp[c]); end
            if (exp_rsp[c] != 4'h0) begin
                checks++; if (rsp_data !== exp_dat[c]) begin errors++; $display("FAIL all4_rsp_data c%0d: got %h want %h", c, rsp_data, exp_dat[c]); end
            end
            if (c == 5) begin
                checks++; if (busy !== 4'b1111) begin errors++; $display("FAIL all4_busy c5: got %b want 1111", busy); end
            end
            cyc();
        end
`ifdef FP16_SCHED_STATS_EN
        checks++; if (stat_grants !== 16'd8) begin errors++; $display("FAIL stat_grants: got %0d want 8", stat_grants); end
        checks++; if (stat_conflicts !== 16'd3) begin errors++; $display("FAIL stat_conflicts: got %0d want 3", stat_conflicts); end
`endif
        req_valid = '0;
        repeat (10) cyc();
    endtask

    task automatic test_busy_skip();
        // t0: req2 alone
        set_ops(2, 16'hC000, 16'h3800);
        req_valid = 4'b0100;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL skip_t0_ready: got %b want 0100", req_ready); end
        cyc();
        // t1: req1 new, req2 still asserting while busy
        req_valid = 4'b0110;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL skip_t1_ready: got %b want 0010", req_ready); end
        cyc();
        // t2: pointer is at 2, but req2 is busy so req3 wins
        req_valid = 4'b1100;
        @(negedge clock);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_t2_ready: got %b want 1000", req_ready); end
        cyc();
        req_valid = 4'b0100;
        for (int t = 3; t <= 5; t++) begin
            @(negedge clock);
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL skip_t%0d_ready: got %b want 0000", t, req_ready); end
            checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL skip_t%0d_busy2: got %b want 1", t, busy[2]); end
            cyc();
        end
        // t6: req2 response and re-grant in the same cycle
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL skip_t6_rsp_valid: got %b want 0100", rsp_valid); end
        checks++; if (rsp_data !== 16'hBC00) begin errors++; $display("FAIL skip_t6_rsp_data: got %h want bc00", rsp_data); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL skip_t6_regrant: got %b want 0100", req_ready); end
        cyc();
        req_valid = '0;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL skip_t7_rsp_valid: got %b want 0010", rsp_valid); end
        checks++; if (rsp_data !== 16'h4600) begin errors++; $display("FAIL skip_t7_rsp_data: got %h want 4600", rsp_data); end
        cyc();
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL skip_t8_rsp_valid: got %b want 1000", rsp_valid); end
        checks++; if (rsp_data !== 16'h4C00) begin errors++; $display("FAIL skip_t8_rsp_data: got %h want 4c00", rsp_data); end
        repeat (4) cyc();
        // t12: response to the re-issue made at t6
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL skip_t12_rsp_valid: got %b want 0100", rsp_valid); end
        checks++; if (rsp_data !== 16'hBC00) begin errors++; $display("FAIL skip_t12_rsp_data: got %h want bc00", rsp_data); end
        repeat (3) cyc();
    endtask

    task automatic test_reset_flush();
        logic [3:0] exp_rdy [3];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100};
        set_ops(0, 16'h441A, 16'h4580);
        set_ops(1, 16'h4000, 16'h4200);
        set_ops(2, 16'hC000, 16'h3800);
        req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL flush_issue_ready c%0d: got %b want %b", c, req_ready, exp_rdy[c]); end
            cyc();
        end
        req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL flush_busy: got %b want 0000", busy); end
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL flush_mult_start: got %b want 0", mult_start); end
        checks++; if (mult_a !== 16'h0000) begin errors++; $display("FAIL flush_mult_a: got %h want 0000", mult_a); end
        checks++; if (mult_b !== 16'h0000) begin errors++; $display("FAIL flush_mult_b: got %h want 0000", mult_b); end
        checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL flush_rsp_data: got %h want 0000", rsp_data); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL flush_rsp_valid: got %b want 0000", rsp_valid); end
        cyc();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL flush_ghost_rsp c%0d: got %b want 0000", c, rsp_valid); end
            cyc();
        end
        // req0 and req3 contend; a stale pointer (3) would pick req3 first
        set_ops(3, 16'h4400, 16'h4400);
        req_valid = 4'b1001;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_first_grant: got %b want 0001", req_ready); end
        cyc();
        req_valid = 4'b1000;
        @(negedge clock);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL flush_second_grant: got %b want 1000", req_ready); end
        cyc();
        req_valid = '0;
        repeat (10) cyc();
    endtask

    task automatic test_idle();
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL idle_mult_start c%0d: got %b want 0", c, mult_start); end
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL idle_rsp_valid c%0d: got %b want 0000", c, rsp_valid); end
            checks++; if (mult_a !== 16'h4400) begin errors++; $display("FAIL idle_mult_a_hold c%0d: got %h want 4400", c, mult_a); end
            checks++; if (mult_b !== 16'h4400) begin errors++; $display("FAIL idle_mult_b_hold c%0d: got %h want 4400", c, mult_b); end
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_busy_skip();
        test_reset_flush();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
